// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: bus widths,
// reset PC default, FSM state encoding and the PC alignment helper.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // after reset, nothing outstanding
        ST_REQ  = 2'd1,   // request outstanding, data will be kept
        ST_HOLD = 2'd2,   // output buffer and skid full, no request
        ST_KILL = 2'd3    // request outstanding, data will be dropped
    } fetch_state_e;

    // Redirect targets are word addresses; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the
// fetch-to-decode handshake. master = fetch controller, slave = environment.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_inst;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  imem_ack, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst,
        output imem_ack, imem_rdata, id_ready
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry output buffer towards decode plus a one-entry skid register
// that absorbs a returning fetch when decode is stalled.
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [ILEN-1:0] push_inst,
    input  logic            ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic            accept
);

    logic            out_valid_r;
    logic [XLEN-1:0] out_pc_r;
    logic [ILEN-1:0] out_inst_r;
    logic            skid_valid_r;
    logic [XLEN-1:0] skid_pc_r;
    logic [ILEN-1:0] skid_inst_r;

    // The output slot can take new data when empty or being consumed now.
    assign accept    = !out_valid_r || ready;
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_inst  = out_inst_r;

    // Buffer/skid update: clear wins, then skid drain, then new push, then consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_pc_r     <= '0;
            out_inst_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_pc_r    <= '0;
            skid_inst_r  <= '0;
        end else if (clear) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (skid_valid_r) begin
            if (ready) begin
                out_pc_r     <= skid_pc_r;
                out_inst_r   <= skid_inst_r;
                skid_valid_r <= 1'b0;
            end
        end else if (push) begin
            if (accept) begin
                out_valid_r <= 1'b1;
                out_pc_r    <= push_pc;
                out_inst_r  <= push_inst;
            end else begin
                skid_valid_r <= 1'b1;
                skid_pc_r    <= push_pc;
                skid_inst_r  <= push_inst;
            end
        end else if (ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation, flush/branch
// redirects, discard of in-flight data after a redirect, and back-pressure
// from decode through the output buffer / skid sub-module.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_pc,
    fetch_ctrl_if.master    bus
);

    fetch_state_e    state_r;
    fetch_state_e    state_nx;
    logic            req_r;
    logic            req_nx;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] addr_nx;
    logic [XLEN-1:0] pend_r;
    logic [XLEN-1:0] pend_nx;

    logic            redirect_s;
    logic [XLEN-1:0] target_s;
    logic            push_s;
    logic            accept_s;

    // Flush outranks branch; the chosen target is word aligned.
    assign redirect_s = flush | branch;
    assign target_s   = align_pc(flush ? flush_pc : branch_pc);

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = addr_r;

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            addr_r  <= RESET_PC;
            pend_r  <= RESET_PC;
        end else begin
            state_r <= state_nx;
            req_r   <= req_nx;
            addr_r  <= addr_nx;
            pend_r  <= pend_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: state_nx = ST_REQ;
            ST_REQ: begin
                if (redirect_s) begin
                    state_nx = bus.imem_ack ? ST_REQ : ST_KILL;
                end else if (bus.imem_ack) begin
                    state_nx = accept_s ? ST_REQ : ST_HOLD;
                end else begin
                    state_nx = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_s || bus.id_ready) begin
                    state_nx = ST_REQ;
                end else begin
                    state_nx = ST_HOLD;
                end
            end
            ST_KILL: begin
                if (bus.imem_ack) begin
                    state_nx = ST_REQ;
                end else begin
                    state_nx = ST_KILL;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Request address, pending redirect target and buffer push for the next cycle.
    always_comb begin
        addr_nx = addr_r;
        pend_nx = pend_r;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_s) begin
                    addr_nx = target_s;
                end else begin
                    addr_nx = addr_r;
                end
            end
            ST_REQ: begin
                if (redirect_s) begin
                    if (bus.imem_ack) begin
                        addr_nx = target_s;
                    end else begin
                        pend_nx = target_s;
                    end
                end else if (bus.imem_ack) begin
                    push_s  = 1'b1;
                    addr_nx = addr_r + PC_STEP;
                end else begin
                    push_s  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    addr_nx = target_s;
                end else begin
                    addr_nx = addr_r;
                end
            end
            ST_KILL: begin
                if (redirect_s) begin
                    pend_nx = target_s;
                end else begin
                    pend_nx = pend_r;
                end
                if (bus.imem_ack) begin
                    addr_nx = redirect_s ? target_s : pend_r;
                end else begin
                    addr_nx = addr_r;
                end
            end
            default: addr_nx = RESET_PC;
        endcase
        req_nx = (state_nx == ST_REQ) || (state_nx == ST_KILL);
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_s),
        .push      (push_s),
        .push_pc   (addr_r),
        .push_inst (bus.imem_rdata),
        .ready     (bus.id_ready),
        .out_valid (bus.if_valid),
        .out_pc    (bus.if_pc),
        .out_inst  (bus.if_inst),
        .accept    (accept_s)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations plus a delivery-order model checked on every cycle.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] branch_pc = 32'h0;
    bit          ack_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .branch    (branch),
        .branch_pc (branch_pc),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its address xor a fixed pattern.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Advance one clock; memory answers the current request in the same cycle when enabled.
    task automatic step();
        @(posedge clk);
        #1;
        bus.imem_ack   = ack_en && bus.imem_req;
        bus.imem_rdata = memf(bus.imem_addr);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ack_en      = 1'b1;
        flush       = 1'b0;
        branch      = 1'b0;
        bus.id_ready = 1'b1;
        bus.imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        check("rst_addr",  bus.imem_addr,         32'h0);
        check("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        rst_n = 1'b1;
    endtask

    // Model: instructions reach decode in address order from RESET_PC,
    // exactly once, restarting at the aligned target after any redirect.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_pend;
        bit          prev_redir;
        exp_pc = 32'h0; prev_addr = 32'h0; prev_pend = 1'b0; prev_redir = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc     = 32'h0;
                prev_pend  = 1'b0;
                prev_redir = 1'b0;
            end else begin
                if (prev_redir) check("redir_clears_valid", {31'h0, bus.if_valid}, 32'h0);
                if (prev_pend) begin
                    check("req_held", {31'h0, bus.imem_req}, 32'h1);
                    check("addr_stable", bus.imem_addr, prev_addr);
                end
                if (bus.if_valid && bus.id_ready) begin
                    check("deliver_pc",   bus.if_pc,   exp_pc);
                    check("deliver_inst", bus.if_inst, memf(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                if (flush)       exp_pc = flush_pc & 32'hFFFF_FFFC;
                else if (branch) exp_pc = branch_pc & 32'hFFFF_FFFC;
                prev_redir = flush || branch;
                prev_pend  = bus.imem_req && !bus.imem_ack;
                prev_addr  = bus.imem_addr;
            end
        end
    end

    initial begin
        bus.id_ready   = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;

        // Back-to-back fetch from reset.
        do_reset();
        step();
        check("a_req0",  {31'h0, bus.imem_req}, 32'h1);
        check("a_addr0", bus.imem_addr, 32'h0000_0000);
        step();
        check("a_addr1", bus.imem_addr, 32'h0000_0004);
        check("a_valid1", {31'h0, bus.if_valid}, 32'h1);
        check("a_pc1",   bus.if_pc,   32'h0000_0000);
        check("a_inst1", bus.if_inst, 32'hC0DE_0000);
        step();
        check("a_addr2", bus.imem_addr, 32'h0000_0008);
        check("a_pc2",   bus.if_pc,   32'h0000_0004);
        check("a_inst2", bus.if_inst, 32'hC0DE_0004);
        repeat (3) step();

        // Decode stall of three cycles: HOLD, then in-order resume.
        do_reset();
        step();
        bus.id_ready = 1'b0;
        step();
        step();
        check("b_hold_req",   {31'h0, bus.imem_req}, 32'h0);
        check("b_hold_valid", {31'h0, bus.if_valid}, 32'h1);
        check("b_hold_pc",    bus.if_pc,     32'h0000_0000);
        check("b_hold_addr",  bus.imem_addr, 32'h0000_0008);
        step();
        check("b_hold_req2",  {31'h0, bus.imem_req}, 32'h0);
        bus.id_ready = 1'b1;
        step();
        check("b_resume_pc",   bus.if_pc,   32'h0000_0004);
        check("b_resume_inst", bus.if_inst, 32'hC0DE_0004);
        check("b_resume_req",  {31'h0, bus.imem_req}, 32'h1);
        check("b_resume_addr", bus.imem_addr, 32'h0000_0008);
        repeat (4) step();

        // Branch while 0x8 is outstanding; ack arrives two cycles later.
        do_reset();
        step();
        step();
        ack_en = 1'b0;
        step();
        check("c_addr8", bus.imem_addr, 32'h0000_0008);
        branch = 1'b1; branch_pc = 32'h0000_0100;
        step();
        branch = 1'b0;
        check("c_kill_req",   {31'h0, bus.imem_req}, 32'h1);
        check("c_kill_addr",  bus.imem_addr, 32'h0000_0008);
        check("c_kill_valid", {31'h0, bus.if_valid}, 32'h0);
        ack_en = 1'b1;
        step();
        step();
        check("c_tgt_addr",  bus.imem_addr, 32'h0000_0100);
        check("c_tgt_valid", {31'h0, bus.if_valid}, 32'h0);
        step();
        check("c_tgt_pc",   bus.if_pc,   32'h0000_0100);
        check("c_tgt_inst", bus.if_inst, 32'hC0DE_0100);
        repeat (3) step();

        // Flush and branch together, unaligned targets.
        do_reset();
        step();
        step();
        flush = 1'b1; flush_pc = 32'h0000_0183;
        branch = 1'b1; branch_pc = 32'h0000_0102;
        step();
        flush = 1'b0; branch = 1'b0;
        check("d_addr",  bus.imem_addr, 32'h0000_0180);
        check("d_valid", {31'h0, bus.if_valid}, 32'h0);
        step();
        check("d_pc",   bus.if_pc,   32'h0000_0180);
        check("d_inst", bus.if_inst, 32'hC0DE_0180);
        repeat (2) step();

        // PC wrap at the top of the address space.
        do_reset();
        step();
        branch = 1'b1; branch_pc = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        check("e_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        check("e_addr_wrap", bus.imem_addr, 32'h0000_0000);
        check("e_pc_top",    bus.if_pc,     32'hFFFF_FFFC);
        check("e_inst_top",  bus.if_inst,   32'h3F21_FFFC);
        step();
        check("e_pc_wrap", bus.if_pc, 32'h0000_0000);
        step();

        // Reset mid-request, stale ack after release.
        check("f_pre_req", {31'h0, bus.imem_req}, 32'h1);
        check("f_pre_pc",  bus.if_pc, 32'h0000_0004);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_rst_req",   {31'h0, bus.imem_req}, 32'h0);
        check("f_rst_addr",  bus.imem_addr, 32'h0000_0000);
        check("f_rst_valid", {31'h0, bus.if_valid}, 32'h0);
        check("f_rst_pc",    bus.if_pc,   32'h0000_0000);
        check("f_rst_inst",  bus.if_inst, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        check("f_first_addr",  bus.imem_addr, 32'h0000_0000);
        check("f_first_req",   {31'h0, bus.imem_req}, 32'h1);
        check("f_first_valid", {31'h0, bus.if_valid}, 32'h0);
        step();
        check("f_first_pc",   bus.if_pc,   32'h0000_0000);
        check("f_first_inst", bus.if_inst, 32'hC0DE_0000);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test");
        $fatal(1, "timeout");
    end

endmodule
